// File: rtl/time_counter.sv
// hh:mm:ss timekeeper: counts rising edges of the divided tick, with a manual set mode.
// Counts and strobes update one clk after a tick rise; no backpressure, strobes are single-cycle.
module time_counter #(
    parameter int HOURS = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_in,
    input  logic        run,
    input  logic        inc_min,
    input  logic        inc_hr,
    output logic [5:0]  sec,
    output logic [5:0]  min,
    output logic [4:0]  hr,
    output logic [23:0] bcd_time,
    output logic        sec_pulse,
    output logic        day_pulse
);

    localparam logic [5:0] LAST_SM = 6'd59;
    localparam logic [4:0] LAST_HR = 5'(HOURS - 1);

    logic       tick_q;
    logic [5:0] sec_q, sec_d;
    logic [5:0] min_q, min_d;
    logic [4:0] hr_q, hr_d;
    logic       sec_pulse_q, sec_pulse_d;
    logic       day_pulse_q, day_pulse_d;
    logic       tick_rise;

    // tick_q resets high so a level already present at reset release is not a second.
    assign tick_rise = tick_in & ~tick_q;

    always_comb begin
        sec_d       = sec_q;
        min_d       = min_q;
        hr_d        = hr_q;
        sec_pulse_d = 1'b0;
        day_pulse_d = 1'b0;
        if (run) begin
            if (tick_rise) begin
                sec_pulse_d = 1'b1;
                if (sec_q == LAST_SM) begin
                    sec_d = 6'd0;
                    if (min_q == LAST_SM) begin
                        min_d = 6'd0;
                        if (hr_q == LAST_HR) begin
                            hr_d        = 5'd0;
                            day_pulse_d = 1'b1;
                        end else begin
                            hr_d = hr_q + 5'd1;
                        end
                    end else begin
                        min_d = min_q + 6'd1;
                    end
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end
        end else begin
            // Minute adjust clears seconds but never carries into hours.
            if (inc_min) begin
                sec_d = 6'd0;
                min_d = (min_q == LAST_SM) ? 6'd0 : min_q + 6'd1;
            end
            if (inc_hr) begin
                hr_d = (hr_q == LAST_HR) ? 5'd0 : hr_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_q      <= 1'b1;
            sec_q       <= 6'd0;
            min_q       <= 6'd0;
            hr_q        <= 5'd0;
            sec_pulse_q <= 1'b0;
            day_pulse_q <= 1'b0;
        end else begin
            tick_q      <= tick_in;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hr_q        <= hr_d;
            sec_pulse_q <= sec_pulse_d;
            day_pulse_q <= day_pulse_d;
        end
    end

    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [5:0] tens;
        logic [5:0] ones;
        tens = v / 6'd10;
        ones = v % 6'd10;
        return {tens[3:0], ones[3:0]};
    endfunction

    assign sec       = sec_q;
    assign min       = min_q;
    assign hr        = hr_q;
    assign sec_pulse = sec_pulse_q;
    assign day_pulse = day_pulse_q;
    assign bcd_time  = {to_bcd({1'b0, hr_q}), to_bcd(min_q), to_bcd(sec_q)};

endmodule

// File: tb/tb_time_counter.sv
// Bench for time_counter: two instances (24 h and 12 h), directed stimulus, queue scoreboard.
module tb_time_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst_v  = 2'b00;
    logic [1:0] tick_v = 2'b00;
    logic [1:0] run_v  = 2'b00;
    logic [1:0] im_v   = 2'b00;
    logic [1:0] ih_v   = 2'b00;
    logic [1:0] chk_v  = 2'b00;

    logic [5:0]  sec0, min0, sec1, min1;
    logic [4:0]  hr0, hr1;
    logic [23:0] bcd0, bcd1;
    logic        sp0, dp0, sp1, dp1;

    time_counter #(.HOURS(24)) dut24 (
        .clk(clk), .rst(rst_v[0]), .tick_in(tick_v[0]), .run(run_v[0]),
        .inc_min(im_v[0]), .inc_hr(ih_v[0]),
        .sec(sec0), .min(min0), .hr(hr0), .bcd_time(bcd0),
        .sec_pulse(sp0), .day_pulse(dp0)
    );

    time_counter #(.HOURS(12)) dut12 (
        .clk(clk), .rst(rst_v[1]), .tick_in(tick_v[1]), .run(run_v[1]),
        .inc_min(im_v[1]), .inc_hr(ih_v[1]),
        .sec(sec1), .min(min1), .hr(hr1), .bcd_time(bcd1),
        .sec_pulse(sp1), .day_pulse(dp1)
    );

    typedef struct {
        string nm;
        int    h;
        int    m;
        int    s;
        bit    sp;
        bit    dp;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int total = 0;
    int bad   = 0;

    function automatic logic [23:0] bcd_of(input int h, input int m, input int s);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic cmp(input string who, input exp_t e, input int h, input int m, input int s,
                       input logic [23:0] b, input logic sp, input logic dp);
        logic [23:0] want_b;
        want_b = bcd_of(e.h, e.m, e.s);
        total++;
        if (h != e.h || m != e.m || s != e.s) begin
            bad++;
            $display("FAIL %s/%s time got %0d:%0d:%0d want %0d:%0d:%0d",
                     who, e.nm, h, m, s, e.h, e.m, e.s);
        end
        total++;
        if (b !== want_b) begin
            bad++;
            $display("FAIL %s/%s bcd got %06h want %06h", who, e.nm, b, want_b);
        end
        total++;
        if (sp !== e.sp || dp !== e.dp) begin
            bad++;
            $display("FAIL %s/%s strobes got sp=%0b dp=%0b want sp=%0b dp=%0b",
                     who, e.nm, sp, dp, e.sp, e.dp);
        end
    endtask

    // Monitors: a strobe or a sample request pops one expectation; a strobe with nothing queued is an error.
    always @(negedge clk) begin
        if (chk_v[0] || sp0 || dp0) begin
            if (q0.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dut24 spurious strobe got sp=%0b dp=%0b want none", sp0, dp0);
            end else begin
                cmp("dut24", q0.pop_front(), int'(hr0), int'(min0), int'(sec0), bcd0, sp0, dp0);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_v[1] || sp1 || dp1) begin
            if (q1.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dut12 spurious strobe got sp=%0b dp=%0b want none", sp1, dp1);
            end else begin
                cmp("dut12", q1.pop_front(), int'(hr1), int'(min1), int'(sec1), bcd1, sp1, dp1);
            end
        end
    end

    // One clk of stimulus; when c is set, the state after that edge is expected to be eh:em:es.
    task automatic step(input bit d, input bit r, input bit t, input bit rn, input bit im,
                        input bit ih, input bit c, input string nm, input int eh, input int em,
                        input int es, input bit esp, input bit edp);
        exp_t e;
        rst_v[d]  = r;
        tick_v[d] = t;
        run_v[d]  = rn;
        im_v[d]   = im;
        ih_v[d]   = ih;
        @(posedge clk);
        #1;
        im_v[d] = 1'b0;
        ih_v[d] = 1'b0;
        if (c) begin
            e.nm = nm; e.h = eh; e.m = em; e.s = es; e.sp = esp; e.dp = edp;
            if (d) q1.push_back(e);
            else   q0.push_back(e);
            chk_v[d] = 1'b1;
        end
        @(negedge clk);
        #1;
        chk_v[d] = 1'b0;
    endtask

    task automatic tick(input bit d, input bit rn, input string nm, input int eh, input int em,
                        input int es, input bit esp, input bit edp);
        step(d, 1'b1, 1'b0, rn, 1'b0, 1'b0, 1'b0, "", 0, 0, 0, 1'b0, 1'b0);
        step(d, 1'b1, 1'b1, rn, 1'b0, 1'b0, 1'b1, nm, eh, em, es, esp, edp);
    endtask

    task automatic setinc(input bit d, input bit im, input bit ih, input string nm,
                          input int eh, input int em, input int es);
        step(d, 1'b1, 1'b0, 1'b0, im, ih, 1'b1, nm, eh, em, es, 1'b0, 1'b0);
    endtask

    initial begin
        // 24-hour instance: reset with tick high, then hold tick high after release.
        step(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "reset", 0, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            step(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, (i == 9), "hold_high", 0, 0, 0, 1'b0, 1'b0);
        tick(0, 1'b1, "first_rise", 0, 0, 1, 1'b1, 1'b0);
        step(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "pulse_one_cycle", 0, 0, 1, 1'b0, 1'b0);
        for (int s = 2; s <= 58; s++) tick(0, 1'b1, "count", 0, 0, s, 1'b1, 1'b0);
        tick(0, 1'b1, "sec59", 0, 0, 59, 1'b1, 1'b0);
        tick(0, 1'b1, "min_carry", 0, 1, 0, 1'b1, 1'b0);
        step(0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, "run_ignores_inc", 0, 1, 0, 1'b0, 1'b0);

        // Set up 23:59:xx, re-enter run on the same edge as a tick rise, roll the day.
        for (int i = 1; i <= 23; i++) setinc(0, 1'b0, 1'b1, "set_hr", i, 1, 0);
        for (int m = 2; m <= 59; m++) setinc(0, 1'b1, 1'b0, "set_min", 23, m, 0);
        step(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "switch_rise", 23, 59, 1, 1'b1, 1'b0);
        for (int s = 2; s <= 59; s++) tick(0, 1'b1, "to_235959", 23, 59, s, 1'b1, 1'b0);
        tick(0, 1'b1, "day24", 0, 0, 0, 1'b1, 1'b1);
        step(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "day_one_cycle", 0, 0, 0, 1'b0, 1'b0);

        // Set mode from 05:59:42.
        for (int i = 1; i <= 5; i++) setinc(0, 1'b0, 1'b1, "set_hr5", i, 0, 0);
        for (int m = 1; m <= 59; m++) setinc(0, 1'b1, 1'b0, "set_min59", 5, m, 0);
        step(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "run_05_59_01", 5, 59, 1, 1'b1, 1'b0);
        for (int s = 2; s <= 42; s++) tick(0, 1'b1, "to_055942", 5, 59, s, 1'b1, 1'b0);
        setinc(0, 1'b1, 1'b0, "inc_min_no_carry", 5, 0, 0);
        setinc(0, 1'b1, 1'b1, "both_inc", 6, 1, 0);
        tick(0, 1'b0, "set_tick_a", 6, 1, 0, 1'b0, 1'b0);
        tick(0, 1'b0, "set_tick_b", 6, 1, 0, 1'b0, 1'b0);
        step(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "leave_set", 6, 1, 0, 1'b0, 1'b0);

        // Reach 12:34:56, then reset together with tick rise and inc pulses.
        for (int i = 7; i <= 12; i++) setinc(0, 1'b0, 1'b1, "set_hr12", i, 1, 0);
        for (int m = 2; m <= 34; m++) setinc(0, 1'b1, 1'b0, "set_min34", 12, m, 0);
        step(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "run_12_34_01", 12, 34, 1, 1'b1, 1'b0);
        for (int s = 2; s <= 56; s++) tick(0, 1'b1, "to_123456", 12, 34, s, 1'b1, 1'b0);
        step(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "", 0, 0, 0, 1'b0, 1'b0);
        step(0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "reset_overrides", 0, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "no_count_after_reset", 0, 0, 0, 1'b0, 1'b0);

        // 12-hour instance: hour wrap in set mode, then 11:59:59 rollover.
        step(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "r12_reset", 0, 0, 0, 1'b0, 1'b0);
        step(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "r12_idle", 0, 0, 0, 1'b0, 1'b0);
        for (int i = 1; i <= 11; i++) setinc(1, 1'b0, 1'b1, "r12_set_hr", i, 0, 0);
        setinc(1, 1'b0, 1'b1, "hr_wrap12", 0, 0, 0);
        for (int i = 1; i <= 11; i++) setinc(1, 1'b0, 1'b1, "r12_set_hr_b", i, 0, 0);
        for (int m = 1; m <= 59; m++) setinc(1, 1'b1, 1'b0, "r12_set_min", 11, m, 0);
        step(1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "r12_switch_rise", 11, 59, 1, 1'b1, 1'b0);
        for (int s = 2; s <= 59; s++) tick(1, 1'b1, "r12_count", 11, 59, s, 1'b1, 1'b0);
        tick(1, 1'b1, "day12", 0, 0, 0, 1'b1, 1'b1);
        step(1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "r12_after_day", 0, 0, 0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        total++;
        if (q0.size() != 0) begin
            bad++;
            $display("FAIL dut24 drain got %0d pending want 0", q0.size());
        end
        total++;
        if (q1.size() != 0) begin
            bad++;
            $display("FAIL dut12 drain got %0d pending want 0", q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/time_counter.md
Name: time_counter

Overview:
- Timekeeping core of the alarm clock. Consumes the divided square wave from the clock-divider stage, detects its rising edges on the system clock, and advances a 24-hour hh:mm:ss count.
- Provides a set mode for manual minute and hour adjustment.
- Presents binary and BCD time to the display/alarm-compare logic, plus one-cycle second and day-rollover strobes.

Parameters:
- HOURS, 24, hour modulus; legal values 12..24; hours count 0..HOURS-1.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
- tick_in  input  1  divided square wave from the clock divider; each 0->1 transition = one second; synchronous to clk.
- run  input  1  1 = run mode (seconds advance on tick), 0 = set mode.
- inc_min  input  1  single-cycle pulse from debounced button; adjusts minutes in set mode.
- inc_hr  input  1  single-cycle pulse; adjusts hours in set mode.
- sec  output  6  seconds 0..59.
- min  output  6  minutes 0..59.
- hr  output  5  hours 0..HOURS-1.
- bcd_time  output  24  {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones}, 4 bits each.
- sec_pulse  output  1  one-cycle strobe when seconds advance.
- day_pulse  output  1  one-cycle strobe on the (HOURS-1):59:59 -> 00:00:00 rollover.

Behaviour:
- Reset (rst=0 at a clk edge): sec=0, min=0, hr=0, sec_pulse=0, day_pulse=0. Edge-detect register tick_q=1, so a tick_in already high at reset release is not counted. Reset overrides all other inputs.
- Edge detect: tick_rise = tick_in & ~tick_q. tick_q <= tick_in every cycle in all modes.
- Latency: counters and sec_pulse update on the first clk edge at which tick_in=1 after being 0. No further update until tick_in returns to 0 and rises again.
- Run mode (run=1) on tick_rise:
  - sec<59: sec+1.
  - sec=59: sec=0 and min advances.
  - min=59 with carry: min=0 and hr advances.
  - hr=HOURS-1 with carry: hr=0 and day_pulse=1 for that cycle.
  - sec_pulse=1 in the cycle the counters update, 0 otherwise.
  - inc_min and inc_hr are ignored.
- Set mode (run=0):
  - tick_rise is ignored; no sec_pulse, no day_pulse.
  - inc_min: min=(min+1) mod 60 and sec=0; no carry into hr.
  - inc_hr: hr=(hr+1) mod HOURS; min and sec unchanged.
  - inc_min and inc_hr in the same cycle: both applied.
- Mode switch: entering or leaving set mode does not alter any count. A tick_rise in the same cycle as run 0->1 is evaluated with the new run value (counted).
- Arithmetic: all wrap comparisons are exact-equality against the modulus minus 1. Counters never hold out-of-range values.
- BCD: bcd_time is combinational from the sec/min/hr registers, zero latency. Each ones digit = value mod 10, each tens digit = value / 10. Unused upper bits of the tens digits are 0.
- Strobes: sec_pulse and day_pulse are registered, never high for two consecutive cycles, and 0 in the cycle following any reset.
- Implementation: no combinational path from tick_in to any output.

Test Plan:
- Reset with tick_in=1, release rst, hold tick_in=1 for 10 cycles -> sec=0, no sec_pulse. Then tick_in 0->1 -> sec=1, sec_pulse=1 for exactly one cycle.
- Run mode from 00:00:58, two tick rises -> 00:00:59 then 00:01:00; bcd_time=0x000100 at the second update.
- Run mode from 23:59:59 (HOURS=24), one tick rise -> 00:00:00, day_pulse=1 and sec_pulse=1 in the same cycle.
- Repeat rollover with HOURS=12 from 11:59:59 -> 00:00:00, day_pulse=1.
- Set mode at 05:59:42:
  - inc_min -> 05:00:00 (no hour carry).
  - inc_hr and inc_min in one cycle -> 06:01:00.
  - tick rises during set mode -> no change, sec_pulse=0.
- Assert rst=0 in the same cycle as tick rise and inc pulses at 12:34:56 -> 00:00:00, both strobes 0, no count on the following cycle while tick_in stays high.
